// File: rtl/mem_responder.sv
// CPU memory-bus responder: 256x16 RAM plus LED (write-only) and switch (read-only) I/O.
// Reads return one cycle after the command edge; writes land on the command edge; err is sticky.
module mem_responder #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        sw,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic [7:0]        led,
  output logic              err
);

  localparam int RAM_AW    = ADDR_W - 1;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        led_q, led_d;
  logic              err_q, err_d;
  logic              ram_we;

  cmd_e              cmd;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_ram, sel_led, sel_sw;

  assign cmd     = cmd_e'(mem_cmd);
  assign ram_idx = mem_addr[RAM_AW-1:0];
  assign sel_ram = ~mem_addr[ADDR_W-1];
  assign sel_led = (mem_addr == LED_ADDR);
  assign sel_sw  = (mem_addr == SW_ADDR);

  always_comb begin
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;
    led_d       = led_q;
    err_d       = err_q;
    ram_we      = 1'b0;
    case (cmd)
      CMD_READ: begin
        rd_valid_d = 1'b1;
        if (sel_ram) begin
          read_data_d = ram_q[ram_idx];
        end else if (sel_sw) begin
          read_data_d = {{(DATA_W-8){1'b0}}, sw};
        end else begin
          // LED is write-only, so reading it is a bus error like an unmapped hole
          read_data_d = '0;
          err_d       = 1'b1;
        end
      end
      CMD_WRITE: begin
        if (sel_ram) begin
          ram_we = 1'b1;
        end else if (sel_led) begin
          led_d = write_data[7:0];
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_RSVD: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      led_q       <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      led_q       <= led_d;
      err_q       <= err_d;
    end
  end

  // RAM contents survive reset; only the write is suppressed while reset is high
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      ram_q[ram_idx] <= write_data;
    end
  end

  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;
  assign led       = led_q;
  assign err       = err_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's memory bus: it accepts mem_cmd / mem_addr / write_data from the CPU and returns read_data. It combines 256 words of 16-bit data RAM with two memory-mapped I/O locations, an 8-bit switch input and an 8-bit LED output register. The block sits beside the CPU at top level, serving both instruction fetch and load/store traffic. All reads are registered, with a fixed one-cycle latency.

## Interface

Parameters:
- ADDR_W, 9, memory address width.
- DATA_W, 16, data word width.
- LED_ADDR, 9'h100, LED register address (write-only).
- SW_ADDR, 9'h140, switch port address (read-only).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_cmd  input  2  bus command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved.
- mem_addr  input  ADDR_W  word address.
- write_data  input  DATA_W  store data, sampled with WRITE.
- sw  input  8  switch levels, sampled on READ of SW_ADDR.
- read_data  output  DATA_W  registered read result.
- rd_valid  output  1  one-cycle pulse marking read_data as updated.
- led  output  8  LED register.
- err  output  1  sticky bus-error flag.

## Operation

- Decode is evaluated on each rising edge for the command present in that cycle. One command is processed per cycle, and commands are not queued.
- Address map:
  - mem_addr[8]==0 selects RAM word mem_addr[7:0].
  - mem_addr==LED_ADDR selects the LED register.
  - mem_addr==SW_ADDR selects the switch port.
  - All other addresses are unmapped.
- READ:
  - RAM: read_data <= RAM[mem_addr[7:0]].
  - SW_ADDR: read_data <= {8'h00, sw}.
  - LED_ADDR or unmapped: read_data <= 16'h0000 and err <= 1.
  - rd_valid <= 1 in all READ cases.
- WRITE:
  - RAM: RAM[mem_addr[7:0]] <= write_data.
  - LED_ADDR: led <= write_data[7:0]. Upper bits are discarded.
  - SW_ADDR or unmapped: no state change except err <= 1.
  - rd_valid <= 0 and read_data holds.
- NONE: no state change, read_data holds, rd_valid <= 0.
- Reserved (2'b11): treated as NONE, except err <= 1.
- err is sticky. It is cleared only by reset.
- Reset:
  - read_data = 16'h0000, rd_valid = 0, led = 8'h00, err = 0.
  - RAM contents are not cleared.
  - Any command in a cycle with reset high is ignored: no RAM write and no err update.

## Timing

- Read latency is 1 cycle. A READ sampled at edge N produces read_data and rd_valid=1 after edge N and holds them until edge N+1.
- read_data holds its last value indefinitely until the next READ. The CPU may consume it in any later cycle.
- Write latency is 0 additional cycles. A WRITE at edge N is visible to a READ of the same address sampled at edge N+1.
- Back-to-back READs produce rd_valid high on consecutive cycles, each carrying its own address's data.
- led changes only on the edge that samples a WRITE to LED_ADDR, or on reset.
- sw is sampled only at the READ edge. Changes between reads are not observed.
- When reset is asserted mid-sequence, the next edge forces the reset values. A READ issued in the same cycle as reset produces rd_valid = 0.

## Test plan

- Reset with no commands: assert reset for 2 cycles, then release. Required: read_data=0, rd_valid=0, led=0, err=0.
- RAM round-trip:
  - Stimulus: WRITE 9'h005 with 16'hBEEF, then READ 9'h005 on the next cycle.
  - Required: read_data=16'hBEEF with rd_valid=1 exactly one cycle after the READ edge. Afterwards, rd_valid=0 and read_data remains 16'hBEEF.
  - Also: WRITE 9'h0FF with 16'h1234 and READ it back to confirm the top RAM word.
- I/O mapping:
  - Stimulus: WRITE LED_ADDR with 16'hABCD, then set sw=8'h5A and READ SW_ADDR.
  - Required: led=8'hCD and read_data=16'h005A. RAM word 9'h000 is unchanged.
- Error flag:
  - Stimulus: READ 9'h1FF.
  - Required: read_data=0, rd_valid=1, err=1.
  - Then issue NONE for 10 cycles: err stays 1. Assert reset: err=0.
  - Separately, issue mem_cmd=2'b11: err=1 and no state change.
- Reset collision:
  - Stimulus: WRITE 9'h010 with 16'h7777 in the same cycle as reset; previous contents are 16'h1111.
  - Required: a subsequent READ of 9'h010 returns 16'h1111.
  - Also: a READ issued with reset high yields rd_valid=0.
